// File: rtl/wd_tel_pkg.sv
// ============================================================================
//  Module      : wd_tel_pkg
//  Description : Shared constants, state encoding and frame-byte helper for
//                the wind telemetry streamer and UART arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wd_tel_pkg;

    localparam logic [7:0] C_HEADER_DEFAULT  = 8'hA5;
    localparam int         C_HOLDOFF_DEFAULT = 400;
    localparam int         C_FRAME_LEN       = 10;
    localparam int         C_IDX_W           = 4;

    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_SEND = 2'd1,
        F_GAP  = 2'd2,
        F_WAIT = 2'd3
    } tel_state_t;

    // Byte at position idx of a telemetry frame; the last byte is the XOR of the payload.
    function automatic logic [7:0] frame_byte(
        input logic [C_IDX_W-1:0] idx,
        input logic [7:0]         header,
        input logic [15:0]        spd,
        input logic [15:0]        dir,
        input logic [15:0]        sx,
        input logic [15:0]        sy
    );
        logic [7:0] csum;
        csum = spd[15:8] ^ spd[7:0] ^ dir[15:8] ^ dir[7:0]
             ^ sx[15:8]  ^ sx[7:0]  ^ sy[15:8]  ^ sy[7:0];
        case (idx)
            4'd0:    return header;
            4'd1:    return spd[15:8];
            4'd2:    return spd[7:0];
            4'd3:    return dir[15:8];
            4'd4:    return dir[7:0];
            4'd5:    return sx[15:8];
            4'd6:    return sx[7:0];
            4'd7:    return sy[15:8];
            4'd8:    return sy[7:0];
            4'd9:    return csum;
            default: return 8'h00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tel_capture.sv
// ============================================================================
//  Module      : tel_capture
//  Description : Decimated snapshot of wind measurements with a pending flag
//                and a saturating count of captures that could not be taken.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tel_capture (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tel_enable,
    input  logic [7:0]  tel_div,
    input  logic        speeden,
    input  logic [15:0] speed,
    input  logic [15:0] direction,
    input  logic [15:0] speedX,
    input  logic [15:0] speedY,
    input  logic        frame_busy,
    input  logic        frame_done,
    output logic        pending,
    output logic [15:0] snap_speed,
    output logic [15:0] snap_direction,
    output logic [15:0] snap_x,
    output logic [15:0] snap_y,
    output logic [7:0]  drop_count
);

    logic [7:0]  r_dec_cnt;
    logic        r_pending;
    logic [15:0] r_snap_speed;
    logic [15:0] r_snap_direction;
    logic [15:0] r_snap_x;
    logic [15:0] r_snap_y;
    logic [7:0]  r_drop_count;

    logic w_attempt;
    logic w_capture;
    logic w_drop;

    assign w_attempt = speeden & tel_enable & (r_dec_cnt == tel_div);
    // A snapshot that is still waiting or being sent must not be overwritten.
    assign w_capture = w_attempt & ~r_pending & ~frame_busy;
    assign w_drop    = w_attempt & ~w_capture;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dec_cnt        <= 8'd0;
            r_pending        <= 1'b0;
            r_snap_speed     <= 16'd0;
            r_snap_direction <= 16'd0;
            r_snap_x         <= 16'd0;
            r_snap_y         <= 16'd0;
            r_drop_count     <= 8'd0;
        end else begin
            if (!tel_enable) begin
                r_dec_cnt <= 8'd0;
            end else if (speeden) begin
                r_dec_cnt <= w_attempt ? 8'd0 : r_dec_cnt + 8'd1;
            end

            if (!tel_enable || frame_done) begin
                r_pending <= 1'b0;
            end else if (w_capture) begin
                r_pending <= 1'b1;
            end

            if (w_capture) begin
                r_snap_speed     <= speed;
                r_snap_direction <= direction;
                r_snap_x         <= speedX;
                r_snap_y         <= speedY;
            end

            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign pending        = r_pending;
    assign snap_speed     = r_snap_speed;
    assign snap_direction = r_snap_direction;
    assign snap_x         = r_snap_x;
    assign snap_y         = r_snap_y;
    assign drop_count     = r_drop_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between the command interpreter
//                and a 10-byte wind telemetry frame streamer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import wd_tel_pkg::*;
#(
    parameter int         HOLDOFF = C_HOLDOFF_DEFAULT,
    parameter logic [7:0] HEADER  = C_HEADER_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tel_enable,
    input  logic [7:0]  tel_div,
    input  logic        speeden,
    input  logic [15:0] speed,
    input  logic [15:0] direction,
    input  logic [15:0] speedX,
    input  logic [15:0] speedY,
    input  logic        cmd_en,
    input  logic [7:0]  cmd_data,
    output logic        cmd_ready,
    input  logic        uart_txready,
    output logic        uart_txen,
    output logic [7:0]  uart_din,
    output logic        frame_busy,
    output logic [7:0]  drop_count
);

    localparam int                C_HO_W    = $clog2(HOLDOFF + 1);
    localparam logic [C_HO_W-1:0] C_HO_LOAD = C_HO_W'(HOLDOFF);

    tel_state_t          r_state;
    tel_state_t          w_state_nxt;
    logic [C_IDX_W-1:0]  r_idx;
    logic [C_IDX_W-1:0]  w_idx_nxt;
    logic [C_HO_W-1:0]   r_holdoff;

    logic        w_pending;
    logic [15:0] w_snap_speed;
    logic [15:0] w_snap_direction;
    logic [15:0] w_snap_x;
    logic [15:0] w_snap_y;
    logic        w_cmd_fwd;
    logic        w_frame_start;
    logic        w_frame_done;
    logic        w_frame_busy;

    // A command offered while the UART is busy is dropped rather than forwarded.
    assign w_cmd_fwd     = (r_state == IDLE) & cmd_en & uart_txready;
    assign w_frame_start = (r_state == IDLE) & w_pending & (r_holdoff == '0)
                         & uart_txready & ~cmd_en;
    assign w_frame_done  = (r_state == F_WAIT) & uart_txready & (r_idx == C_LAST_IDX);
    assign w_frame_busy  = (r_state != IDLE);

    tel_capture u_capture (
        .clock          (clock),
        .reset_n        (reset_n),
        .tel_enable     (tel_enable),
        .tel_div        (tel_div),
        .speeden        (speeden),
        .speed          (speed),
        .direction      (direction),
        .speedX         (speedX),
        .speedY         (speedY),
        .frame_busy     (w_frame_busy),
        .frame_done     (w_frame_done),
        .pending        (w_pending),
        .snap_speed     (w_snap_speed),
        .snap_direction (w_snap_direction),
        .snap_x         (w_snap_x),
        .snap_y         (w_snap_y),
        .drop_count     (drop_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_holdoff <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_cmd_fwd) begin
                r_holdoff <= C_HO_LOAD;
            end else if (r_holdoff != '0) begin
                r_holdoff <= r_holdoff - 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        cmd_ready   = 1'b0;
        uart_txen   = 1'b0;
        uart_din    = frame_byte(r_idx, HEADER, w_snap_speed, w_snap_direction,
                                 w_snap_x, w_snap_y);
        case (r_state)
            IDLE: begin
                cmd_ready = uart_txready;
                uart_txen = w_cmd_fwd;
                uart_din  = cmd_data;
                if (w_frame_start) begin
                    w_state_nxt = F_SEND;
                    w_idx_nxt   = '0;
                end
            end
            F_SEND: begin
                uart_txen   = 1'b1;
                w_state_nxt = F_GAP;
            end
            // txready still reflects the previous byte here, so skip one cycle.
            F_GAP: begin
                w_state_nxt = F_WAIT;
            end
            F_WAIT: begin
                if (uart_txready) begin
                    if (r_idx == C_LAST_IDX) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = F_SEND;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign frame_busy = w_frame_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed self-checking bench for uart_tx_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        tel_enable;
    logic [7:0]  tel_div;
    logic        speeden;
    logic [15:0] speed;
    logic [15:0] direction;
    logic [15:0] speedX;
    logic [15:0] speedY;
    logic        cmd_en;
    logic [7:0]  cmd_data;
    logic        cmd_ready;
    logic        uart_txready;
    logic        uart_txen;
    logic [7:0]  uart_din;
    logic        frame_busy;
    logic [7:0]  drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int busy    = 0;
    logic saw_txen = 1'b0;

    int         log_cyc[$];
    logic [7:0] log_dat[$];

    uart_tx_arbiter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tel_enable   (tel_enable),
        .tel_div      (tel_div),
        .speeden      (speeden),
        .speed        (speed),
        .direction    (direction),
        .speedX       (speedX),
        .speedY       (speedY),
        .cmd_en       (cmd_en),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .uart_txready (uart_txready),
        .uart_txen    (uart_txen),
        .uart_din     (uart_din),
        .frame_busy   (frame_busy),
        .drop_count   (drop_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // UART model: txready low for 20 cycles starting the cycle after a txen pulse.
    assign uart_txready = (busy == 0);
    always @(negedge clock) begin
        saw_txen = (uart_txen === 1'b1);
        if (uart_txen === 1'b1) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(uart_din);
        end
    end
    always @(posedge clock) begin
        #1;
        if (saw_txen) busy = 20;
        else if (busy != 0) busy = busy - 1;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        int k;
        k = 0;
        while (log_dat.size() < n && k < budget) begin
            tick(1);
            k++;
        end
    endtask

    task automatic pulse_speeden(output int c);
        speeden = 1'b1;
        c = cyc;
        tick(1);
        speeden = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; tel_enable = 1'b0; tel_div = 8'd0; speeden = 1'b0;
        speed = '0; direction = '0; speedX = '0; speedY = '0;
        cmd_en = 1'b0; cmd_data = 8'h00;
        tick(3);
        @(negedge clock);
        n_tests++; if (uart_txen !== 1'b0) begin n_fail++; $display("FAIL reset_txen: got %b want 0", uart_txen); end
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", frame_busy); end
        n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        tick(1);
        reset_n = 1'b1;
        tick(3);
    endtask

    task automatic test_passthrough;
        int t1, t2;
        log_cyc.delete(); log_dat.delete();
        cmd_en = 1'b1; cmd_data = 8'h41; t1 = cyc;
        @(negedge clock);
        n_tests++; if (uart_txen !== 1'b1 || uart_din !== 8'h41) begin n_fail++; $display("FAIL pass_first: got txen=%b din=%h want 1/41", uart_txen, uart_din); end
        tick(1); cmd_en = 1'b0;
        tick(25);
        cmd_en = 1'b1; cmd_data = 8'h42; t2 = cyc;
        tick(1);
        // UART is now busy: this command must be ignored.
        cmd_data = 8'h99;
        @(negedge clock);
        n_tests++; if (uart_txen !== 1'b0 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL pass_violation: got txen=%b ready=%b want 0/0", uart_txen, cmd_ready); end
        tick(1); cmd_en = 1'b0;
        tick(2);
        n_tests++; if (log_dat.size() !== 2) begin n_fail++; $display("FAIL pass_count: got %0d want 2", log_dat.size()); end
        n_tests++; if (log_cyc[0] !== t1 || log_dat[0] !== 8'h41 || log_cyc[1] !== t2 || log_dat[1] !== 8'h42)
            begin n_fail++; $display("FAIL pass_bytes: got %0d:%h %0d:%h want %0d:41 %0d:42", log_cyc[0], log_dat[0], log_cyc[1], log_dat[1], t1, t2); end
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL pass_busy: got %b want 0", frame_busy); end
    endtask

    task automatic test_single_frame;
        int c;
        logic [7:0] exp_b [10];
        exp_b = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'h01};
        tick(500);
        log_cyc.delete(); log_dat.delete();
        tel_enable = 1'b1; tel_div = 8'd0;
        speed = 16'h1234; direction = 16'h5678; speedX = 16'h9ABC; speedY = 16'hDEF1;
        tick(2);
        pulse_speeden(c);
        wait_log(1, 50);
        n_tests++; if (frame_busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL frame_busy_mid: got busy=%b ready=%b want 1/0", frame_busy, cmd_ready); end
        wait_log(10, 600);
        tick(30);
        n_tests++; if (log_dat.size() !== 10) begin n_fail++; $display("FAIL frame_len: got %0d want 10", log_dat.size()); end
        n_tests++; if (log_cyc[0] !== c + 2) begin n_fail++; $display("FAIL frame_latency: got %0d want %0d", log_cyc[0], c + 2); end
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (log_dat[i] !== exp_b[i]) begin n_fail++; $display("FAIL frame_byte%0d: got %h want %h", i, log_dat[i], exp_b[i]); end
        end
        n_tests++; if (frame_busy !== 1'b0 || drop_count !== 8'd0) begin n_fail++; $display("FAIL frame_end: got busy=%b drop=%0d want 0/0", frame_busy, drop_count); end
    endtask

    task automatic test_holdoff;
        int t, c;
        logic [7:0] exp_b [10];
        exp_b = '{8'hA5, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h80, 8'h00, 8'hFF, 8'hFF, 8'h7E};
        log_cyc.delete(); log_dat.delete();
        speed = 16'h00FF; direction = 16'h0100; speedX = 16'h8000; speedY = 16'hFFFF;
        cmd_en = 1'b1; cmd_data = 8'h43; t = cyc;
        tick(1); cmd_en = 1'b0;
        tick(9);
        pulse_speeden(c);
        tick(189);
        cmd_en = 1'b1; cmd_data = 8'h55;
        n_tests++; if (cyc !== t + 200) begin n_fail++; $display("FAIL holdoff_sched: got %0d want %0d", cyc, t + 200); end
        tick(1); cmd_en = 1'b0;
        wait_log(12, 1200);
        tick(30);
        n_tests++; if (log_dat.size() !== 12) begin n_fail++; $display("FAIL holdoff_count: got %0d want 12", log_dat.size()); end
        n_tests++; if (log_cyc[1] !== t + 200 || log_dat[1] !== 8'h55) begin n_fail++; $display("FAIL holdoff_cmd2: got %0d:%h want %0d:55", log_cyc[1], log_dat[1], t + 200); end
        n_tests++; if (log_cyc[2] !== t + 602) begin n_fail++; $display("FAIL holdoff_start: got %0d want %0d", log_cyc[2], t + 602); end
        for (int i = 0; i < 10; i++) begin
            n_tests++; if (log_dat[i+2] !== exp_b[i]) begin n_fail++; $display("FAIL holdoff_byte%0d: got %h want %h", i, log_dat[i+2], exp_b[i]); end
        end
    endtask

    task automatic test_decimation;
        int c, c3;
        c3 = 0;
        log_cyc.delete(); log_dat.delete();
        tel_div = 8'd2;
        direction = '0; speedX = '0; speedY = '0;
        for (int i = 1; i <= 6; i++) begin
            speed = {8'h10, 8'(i)};
            pulse_speeden(c);
            if (i == 3) c3 = c;
            tick(49);
        end
        wait_log(10, 500);
        tick(300);
        n_tests++; if (log_dat.size() !== 10) begin n_fail++; $display("FAIL dec_count: got %0d want 10", log_dat.size()); end
        n_tests++; if (log_cyc[0] !== c3 + 2) begin n_fail++; $display("FAIL dec_start: got %0d want %0d", log_cyc[0], c3 + 2); end
        n_tests++; if (log_dat[1] !== 8'h10 || log_dat[2] !== 8'h03 || log_dat[9] !== 8'h13)
            begin n_fail++; $display("FAIL dec_bytes: got %h %h %h want 10 03 13", log_dat[1], log_dat[2], log_dat[9]); end
        n_tests++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL dec_drop: got %0d want 1", drop_count); end
    endtask

    task automatic test_saturation;
        tel_div = 8'd0;
        speeden = 1'b1;
        tick(10);
        @(negedge clock);
        n_tests++; if (drop_count !== 8'd10) begin n_fail++; $display("FAIL sat_partial: got %0d want 10", drop_count); end
        tick(290);
        speeden = 1'b0;
        @(negedge clock);
        n_tests++; if (drop_count !== 8'd255) begin n_fail++; $display("FAIL sat_full: got %0d want 255", drop_count); end
        tick(600);
    endtask

    task automatic test_reset_mid_frame;
        int c;
        log_cyc.delete(); log_dat.delete();
        pulse_speeden(c);
        wait_log(5, 500);
        n_tests++; if (log_dat.size() !== 5) begin n_fail++; $display("FAIL rst_prep: got %0d want 5", log_dat.size()); end
        tick(1);
        reset_n = 1'b0;
        @(negedge clock);
        n_tests++; if (uart_txen !== 1'b0 || frame_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out: got txen=%b busy=%b want 0/0", uart_txen, frame_busy); end
        n_tests++; if (drop_count !== 8'd0) begin n_fail++; $display("FAIL rst_mid_drop: got %0d want 0", drop_count); end
        n_tests++; if (cmd_ready !== uart_txready) begin n_fail++; $display("FAIL rst_mid_ready: got %b want %b", cmd_ready, uart_txready); end
        tick(3);
        reset_n = 1'b1;
        tick(600);
        n_tests++; if (log_dat.size() !== 5) begin n_fail++; $display("FAIL rst_no_more: got %0d want 5", log_dat.size()); end
    endtask

    task automatic test_simultaneous;
        int c;
        tick(30);
        log_cyc.delete(); log_dat.delete();
        speed = 16'hCAFE; direction = 16'hBEEF; speedX = 16'h0102; speedY = 16'h0304;
        pulse_speeden(c);
        cmd_en = 1'b1; cmd_data = 8'h77;
        speed = '0; direction = '0; speedX = '0; speedY = '0;
        @(negedge clock);
        n_tests++; if (uart_txen !== 1'b1 || uart_din !== 8'h77) begin n_fail++; $display("FAIL sim_cmd: got txen=%b din=%h want 1/77", uart_txen, uart_din); end
        tick(1); cmd_en = 1'b0;
        wait_log(11, 1200);
        n_tests++; if (log_dat.size() !== 11) begin n_fail++; $display("FAIL sim_count: got %0d want 11", log_dat.size()); end
        n_tests++; if (log_cyc[1] !== c + 403 || log_dat[1] !== 8'hA5) begin n_fail++; $display("FAIL sim_start: got %0d:%h want %0d:a5", log_cyc[1], log_dat[1], c + 403); end
        n_tests++; if (log_dat[2] !== 8'hCA || log_dat[3] !== 8'hFE || log_dat[10] !== 8'h61)
            begin n_fail++; $display("FAIL sim_snapshot: got %h %h %h want ca fe 61", log_dat[2], log_dat[3], log_dat[10]); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_single_frame();
        test_holdoff();
        test_decimation();
        test_saturation();
        test_reset_mid_frame();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
